and_pipe_driver: RTL and testbench

AND_PIPE_DRIVER -- requirements
Module: and_pipe_driver

---
 rtl/and_pipe_driver.sv | 192 +++++++++++++++++++
 tb/tb_and_pipe_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/and_pipe_driver.sv
`default_nettype none
// ============================================================================
// Module   : and_pipe_driver
// Purpose  : Self-test driver for a 2-input AND pipeline with latency LAT.
//            It drives num_vec stimulus vectors on {in1,in0}, one per cycle,
//            and checks out_dut against the expected AND result LAT cycles
//            later. It counts mismatches in a saturating err_cnt and reports
//            done/pass at the end of the run.
//
// Parameters:
//   LAT    - pipeline latency under test, 1..7 (default 2)
//   CNT_W  - width of num_vec and err_cnt (default 8)
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst      in   asynchronous active-high reset
//   start    in   run request, sampled only while idle
//   num_vec  in   vectors per run, captured together with start
//   in0      out  stimulus bit 0 to the pipeline
//   in1      out  stimulus bit 1 to the pipeline
//   out_dut  in   pipeline result
//   busy     out  high while driving vectors or draining the pipeline
//   done     out  one-cycle end-of-run pulse
//   err_cnt  out  mismatch count of the current or last run (saturating)
//   pass     out  valid with done; high iff err_cnt == 0
//
// Build option:
//   AND_PIPE_DRIVER_LFSR_EN - when defined, vectors are the low two bits of
//   an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01). When undefined,
//   vectors come from a 2-bit up-counter starting at 00.
//
// Revision : 1.0 - initial release
// ============================================================================
module and_pipe_driver #(
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             in0,
    output logic             in1,
    input  logic             out_dut,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [2:0]       c_DRAIN_LAST = 3'(LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ERR_MAX    = '1;

`ifdef AND_PIPE_DRIVER_LFSR_EN
    localparam int                c_PAT_W    = 8;
    localparam logic [c_PAT_W-1:0] c_PAT_SEED = 8'h01;

    // Fibonacci LFSR: taps at bits 7,5,4,3, shifting toward the MSB.
    function automatic logic [c_PAT_W-1:0] f_pat_step(input logic [c_PAT_W-1:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction
`else
    localparam int                c_PAT_W    = 2;
    localparam logic [c_PAT_W-1:0] c_PAT_SEED = 2'b00;

    function automatic logic [c_PAT_W-1:0] f_pat_step(input logic [c_PAT_W-1:0] p);
        return p + 2'b01;
    endfunction
`endif

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_vec_cnt;    // vectors still to drive after the current one
    logic [2:0]         r_drain_cnt;  // drain cycles left after the current one
    logic [c_PAT_W-1:0] r_pat;        // pattern state holding the NEXT vector
    logic               r_drv_vld;    // {in1,in0} currently carries a real vector
    logic [LAT-1:0]     r_exp;        // expected results in flight
    logic [LAT-1:0]     r_tag;        // valid tags matching r_exp

    logic [1:0]         w_seed_vec;
    logic [c_PAT_W-1:0] w_seed_next;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_err_next;

    assign w_seed_vec  = c_PAT_SEED[1:0];
    assign w_seed_next = f_pat_step(c_PAT_SEED);

    // The last tag stage lines up with out_dut for the vector driven LAT
    // cycles earlier; only tagged cycles can count as mismatches.
    assign w_mismatch = r_tag[LAT-1] && (out_dut != r_exp[LAT-1]);
    assign w_err_next = (w_mismatch && (err_cnt != c_ERR_MAX)) ? (err_cnt + c_CNT_ONE)
                                                               : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
            r_pat       <= '0;
            r_drv_vld   <= 1'b0;
            r_exp       <= '0;
            r_tag       <= '0;
            in0         <= 1'b0;
            in1         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
        end else begin
            // Expected-value delay line tracks whatever is on the outputs.
            r_exp[0] <= in0 & in1;
            r_tag[0] <= r_drv_vld;
            for (int i = 1; i < LAT; i++) begin
                r_exp[i] <= r_exp[i-1];
                r_tag[i] <= r_tag[i-1];
            end

            err_cnt <= w_err_next;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        err_cnt <= '0;
                        r_pat   <= c_PAT_SEED;
                        if (num_vec != '0) begin
                            // First vector goes out immediately; r_pat then
                            // holds the one after it.
                            r_state    <= c_RUN;
                            busy       <= 1'b1;
                            {in1, in0} <= w_seed_vec;
                            r_pat      <= w_seed_next;
                            r_drv_vld  <= 1'b1;
                            r_vec_cnt  <= num_vec - c_CNT_ONE;
                        end else begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end
                    end
                end

                c_RUN: begin
                    if (r_vec_cnt == '0) begin
                        r_state     <= c_DRAIN;
                        {in1, in0}  <= 2'b00;
                        r_drv_vld   <= 1'b0;
                        r_drain_cnt <= c_DRAIN_LAST;
                    end else begin
                        {in1, in0} <= r_pat[1:0];
                        r_pat      <= f_pat_step(r_pat);
                        r_vec_cnt  <= r_vec_cnt - c_CNT_ONE;
                    end
                end

                c_DRAIN: begin
                    if (r_drain_cnt == 3'd0) begin
                        // The final comparison happens on this same edge,
                        // so pass must use the updated count.
                        r_state <= c_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end

                default: begin
                    r_state    <= c_IDLE;
                    {in1, in0} <= 2'b00;
                    r_drv_vld  <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_and_pipe_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_and_pipe_driver
// Purpose  : Self-checking bench for and_pipe_driver. An external AND pipeline
//            model (ideal, stuck-at-0, stuck-at-1) feeds out_dut. A table of
//            runs is applied, and the expected vectors are queued per run and
//            popped as the driver emits them. Reset-abort is a hand sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_pipe_driver;

    localparam int LAT   = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in0, in1, out_dut, busy, done, pass;
    logic [CNT_W-1:0] err_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int mode   = 0;           // 0 ideal pipeline, 1 stuck-at-0, 2 stuck-at-1
    logic [LAT-1:0] pipe = '0;

    always #5 clk = ~clk;

    // External AND pipeline with LAT cycles of latency.
    always @(posedge clk) pipe <= {pipe[LAT-2:0], in0 & in1};
    assign out_dut = (mode == 0) ? pipe[LAT-1] : (mode == 2);

    and_pipe_driver #(.LAT(LAT), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_vec (num_vec),
        .in0     (in0),
        .in1     (in1),
        .out_dut (out_dut),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .pass    (pass)
    );

    typedef struct {
        int mode;
        int n;
        int exp_err;
        bit exp_pass;
        bit glitch;
    } run_t;

    run_t       tbl[6];
    logic [1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stimulus sequence, generated from scratch for each index.
    function automatic logic [1:0] vec_at(input int k);
`ifdef AND_PIPE_DRIVER_LFSR_EN
        logic [7:0] l = 8'h01;
        for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l[1:0];
`else
        return 2'(k);
`endif
    endfunction

    function automatic int model_err(input int m, input int n);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            logic [1:0] v = vec_at(k);
            logic       x = v[0] & v[1];
            if (m == 1 && x != 1'b0) e++;
            if (m == 2 && x != 1'b1) e++;
        end
        if (e > (1 << CNT_W) - 1) e = (1 << CNT_W) - 1;
        return e;
    endfunction

    task automatic run(input run_t t);
        logic [1:0] ev;
        mode = t.mode;
        sb.delete();
        for (int k = 0; k < t.n; k++) sb.push_back(vec_at(k));
        @(negedge clk);
        start   = 1'b1;
        num_vec = CNT_W'(t.n);
        @(negedge clk);                       // cycle 1
        start   = 1'b0;
        num_vec = CNT_W'($urandom);           // changes after capture must not matter
        if (t.n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_err",  32'(err_cnt), 32'd0);
            chk("zero_pass", 32'(pass), 32'd1);
        end else begin
            for (int k = 0; k < t.n; k++) begin
                ev = sb.pop_front();
                chk("vector", 32'({in1, in0}), 32'(ev));
                chk("busy_run", 32'(busy), 32'd1);
                if (k == 0) chk("done_run", 32'(done), 32'd0);
                if (t.glitch) start = (k < t.n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            for (int d = 0; d < LAT; d++) begin
                chk("drain_in",   32'({in1, in0}), 32'd0);
                chk("drain_busy", 32'(busy), 32'd1);
                chk("drain_done", 32'(done), 32'd0);
                @(negedge clk);
            end
            // cycle N+LAT+1
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy",  32'(busy), 32'd0);
            chk("err_cnt",    32'(err_cnt), 32'(t.exp_err));
            chk("pass",       32'(pass), 32'(t.exp_pass));
        end
        @(negedge clk);
        chk("done_end", 32'(done), 32'd0);
        chk("idle_in",  32'({in1, in0}), 32'd0);
        chk("err_hold", 32'(err_cnt), 32'(t.exp_err));
    endtask

    initial begin
        run_t r;
        rst     = 1'b1;
        start   = 1'b0;
        num_vec = '0;

        tbl[0] = '{0, 4,   model_err(0, 4),   1'b0, 1'b0};
        tbl[1] = '{1, 8,   model_err(1, 8),   1'b0, 1'b0};
        tbl[2] = '{0, 0,   0,                 1'b0, 1'b0};
        tbl[3] = '{2, 255, model_err(2, 255), 1'b0, 1'b1};
        tbl[4] = '{0, 20,  model_err(0, 20),  1'b0, 1'b0};
        tbl[5] = '{2, 3,   model_err(2, 3),   1'b0, 1'b0};
        for (int i = 0; i < 6; i++) tbl[i].exp_pass = (tbl[i].exp_err == 0);

        repeat (3) @(negedge clk);
        chk("rst_in",   32'({in1, in0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err",  32'(err_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run(tbl[i]);

        // Reset during a run: outputs clear at once, no done pulse follows.
        mode = 2;                               // stuck-at-1 builds up errors
        @(negedge clk);
        start   = 1'b1;
        num_vec = CNT_W'(10);
        @(negedge clk);                         // cycle 1
        start = 1'b0;
        @(negedge clk);                         // cycle 2
        @(negedge clk);                         // cycle 3
        #2 rst = 1'b1;
        #1;
        chk("abort_in",   32'({in1, in0}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_err",  32'(err_cnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            chk("post_abort_idle", 32'({busy, done}), 32'd0);
        end
        r = '{0, 2, 0, 1'b1, 1'b0};
        run(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
